// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single data-memory port between the CPU load/store
//            path (port 0) and an auxiliary master (port 1). A registered FSM
//            grants one requester per cycle. It alternates between ports when
//            both are busy and lets the owner keep the port for up to
//            MAX_BURST locked beats. Read data is captured into a register and
//            flagged with a one-cycle valid pulse.
// Ports    : clk, rst                   clock, synchronous active-high reset
//            req*_i, lock*_i, we*_i     per-port request / burst lock / write
//            addr*_i, wdata*_i          per-port byte address and write data
//            dsize*_i                   bytes-1 (3 word, 1 half, 0 byte)
//            gnt*_o                     access performed this cycle
//            rdata*_o, rvalid*_o        registered read word and valid pulse
//            err*_o                     rejected-access pulse
//            mem_*_o, mem_rdata_i       dmem port (combinational read)
// Options  : DMEM_ARB_ALIGN_CHECK_EN    reject invalid size / misaligned
//                                       accesses in the grant cycle
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        lock0_i,
  input  logic        lock1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [0:31] addr0_i,
  input  logic [0:31] addr1_i,
  input  logic [0:31] wdata0_i,
  input  logic [0:31] wdata1_i,
  input  logic [0:1]  dsize0_i,
  input  logic [0:1]  dsize1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic [0:31] rdata0_o,
  output logic [0:31] rdata1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [0:31] mem_addr_o,
  output logic [0:31] mem_wdata_o,
  output logic        mem_we_o,
  output logic [0:1]  mem_dsize_o,
  input  logic [0:31] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Beat index of the final beat a locked owner may take before release.
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;     // last port served; 1 lets port 0 win the first tie
  logic [3:0]  beat_q, beat_d;
  logic [0:31] rdata0_q, rdata1_q;
  logic        rvalid0_q, rvalid1_q;
  logic        err0_q, err1_q;

  logic        w_gnt0, w_gnt1;
  logic        w_own_req, w_own_lock, w_own_we, w_other_req;
  logic [0:31] w_own_addr, w_own_wdata;
  logic [0:1]  w_own_dsize;
  logic        w_reject;
  logic        w_rd_ok;

  // Owner multiplexer: everything the memory sees comes from the owning port.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_own_req   = 1'b0;
    w_own_lock  = 1'b0;
    w_own_we    = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    w_own_dsize = '0;
    w_other_req = 1'b0;
    case (state_q)
      OWN0: begin
        w_gnt0      = 1'b1;
        w_own_req   = req0_i;
        w_own_lock  = lock0_i;
        w_own_we    = we0_i;
        w_own_addr  = addr0_i;
        w_own_wdata = wdata0_i;
        w_own_dsize = dsize0_i;
        w_other_req = req1_i;
      end
      OWN1: begin
        w_gnt1      = 1'b1;
        w_own_req   = req1_i;
        w_own_lock  = lock1_i;
        w_own_we    = we1_i;
        w_own_addr  = addr1_i;
        w_own_wdata = wdata1_i;
        w_own_dsize = dsize1_i;
        w_other_req = req0_i;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  // Size 2 is not a legal encoding; words need addr[30:31]=0, halves addr[31]=0.
  always_comb begin
    w_reject = 1'b0;
    if (w_gnt0 || w_gnt1) begin
      case (w_own_dsize)
        2'd2:    w_reject = 1'b1;
        2'd3:    w_reject = (w_own_addr[30:31] != 2'b00);
        2'd1:    w_reject = w_own_addr[31];
        default: w_reject = 1'b0;
      endcase
    end
  end
`else
  // Without the checker nothing is ever rejected, so err0_o/err1_o stay 0.
  assign w_reject = 1'b0;
`endif

  assign w_rd_ok = ~w_own_we & ~w_reject;

  // Next-state logic. The owner's req in a grant cycle belongs to the beat
  // being performed, so only a locked request can keep ownership.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        beat_d = 4'd0;
        if (req0_i && req1_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0_i) begin
          state_d = OWN0;
        end else if (req1_i) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        last_d = (state_q == OWN1);
        if (w_own_req && w_own_lock && !w_reject && (beat_q < LAST_BEAT)) begin
          beat_d = beat_q + 4'd1;
        end else begin
          beat_d = 4'd0;
          if (w_other_req) begin
            state_d = (state_q == OWN0) ? OWN1 : OWN0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      beat_q    <= 4'd0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      rvalid0_q <= w_gnt0 & w_rd_ok;
      rvalid1_q <= w_gnt1 & w_rd_ok;
      err0_q    <= w_gnt0 & w_reject;
      err1_q    <= w_gnt1 & w_reject;
      if (w_gnt0 && w_rd_ok) begin
        rdata0_q <= mem_rdata_i;
      end
      if (w_gnt1 && w_rd_ok) begin
        rdata1_q <= mem_rdata_i;
      end
    end
  end

  assign gnt0_o      = w_gnt0;
  assign gnt1_o      = w_gnt1;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
  assign mem_addr_o  = w_own_addr;
  assign mem_wdata_o = w_own_wdata;
  assign mem_dsize_o = w_own_dsize;
  // Gating with rst keeps a reset landing mid-burst from committing a write.
  assign mem_we_o    = w_own_we & ~rst & ~w_reject;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a big-endian
//            byte-addressable memory model and per-port request queues.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic        lock;
    logic [0:31] addr;
    logic [0:31] wdata;
    logic [0:1]  dsize;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [0:31] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [0:1]  dsize0 = '0, dsize1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [0:31] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [0:1]  mem_dsize;

  logic [0:31] mem [0:255];
  beat_t       q0[$], q1[$];
  logic        g0_prev = 1'b0, g1_prev = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
    .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .dsize0_i(dsize0), .dsize1_i(dsize1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .err0_o(err0), .err1_o(err1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_dsize_o(mem_dsize), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Big-endian memory: byte offset 0 lives in bits [0:7] of the word.
  function automatic logic [0:31] merge(input logic [0:31] old, input logic [0:31] wd,
                                        input logic [0:1] sz, input logic [0:1] off);
    logic [0:31] r;
    r = old;
    case (sz)
      2'd3, 2'd2: r = wd;
      2'd1: if (off[0]) r[16:31] = wd[16:31]; else r[0:15] = wd[16:31];
      default: begin
        case (off)
          2'd0:    r[0:7]   = wd[24:31];
          2'd1:    r[8:15]  = wd[24:31];
          2'd2:    r[16:23] = wd[24:31];
          default: r[24:31] = wd[24:31];
        endcase
      end
    endcase
    return r;
  endfunction

  assign mem_rdata = mem[mem_addr[22:29]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[22:29]] <= merge(mem[mem_addr[22:29]], mem_wdata, mem_dsize, mem_addr[30:31]);
    end
  end

  // Requester model: presents the queue head and advances only after the
  // cycle in which its grant was seen.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (g0_prev && q0.size() > 0) q0.delete(0);
      if (g1_prev && q1.size() > 0) q1.delete(0);
    end
    if (q0.size() > 0) begin
      req0 = 1'b1; we0 = q0[0].we; lock0 = q0[0].lock;
      addr0 = q0[0].addr; wdata0 = q0[0].wdata; dsize0 = q0[0].dsize;
    end else begin
      req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0; dsize0 = '0;
    end
    if (q1.size() > 0) begin
      req1 = 1'b1; we1 = q1[0].we; lock1 = q1[0].lock;
      addr1 = q1[0].addr; wdata1 = q1[0].wdata; dsize1 = q1[0].dsize;
    end else begin
      req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0; dsize1 = '0;
    end
    g0_prev = gnt0;
    g1_prev = gnt1;
  end

  function automatic beat_t mk(input logic we, input logic lock, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] sz);
    beat_t b;
    b.we = we; b.lock = lock; b.addr = a; b.wdata = d; b.dsize = sz;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for the port's grant; returns at the negedge of that cycle.
  task automatic wait_gnt(input int p, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (((p == 0) ? gnt0 : gnt1) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'((p == 0) ? gnt0 : gnt1), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; mem_clr = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_flags", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we}), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);

    // Word write: grant exactly one cycle after req rises
    q0.push_back(mk(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 2'd3));
    @(negedge clk); chk("t1_wr_nognt", 32'(gnt0), 32'd0);
    @(negedge clk); chk("t1_wr_gnt", 32'(gnt0), 32'd1);
    chk("t1_wr_we", 32'(mem_we), 32'd1);
    chk("t1_wr_addr", mem_addr, 32'h100);
    @(negedge clk); chk("t1_wr_done", 32'(gnt0), 32'd0);
    chk("t1_mem", mem[64], 32'hDEADBEEF);
    // Read back: rvalid two cycles after req
    q0.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 2'd3));
    @(negedge clk); chk("t1_rd_nognt", 32'(gnt0), 32'd0);
    @(negedge clk); chk("t1_rd_gnt", 32'(gnt0), 32'd1);
    chk("t1_rd_we", 32'(mem_we), 32'd0);
    @(negedge clk); chk("t1_rvalid", 32'(rvalid0), 32'd1);
    chk("t1_rdata", rdata0, 32'hDEADBEEF);
    @(negedge clk); chk("t1_rvalid_pulse", 32'(rvalid0), 32'd0);

    // Both ports busy out of reset: 0,1,0,1,0,1 with no idle cycles
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 2'd3));
      q1.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0, 2'd3));
    end
    @(negedge clk); chk("t2_nognt", 32'({gnt0, gnt1}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t2_alt%0d", i), 32'({gnt0, gnt1}), (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    @(negedge clk); chk("t2_idle", 32'({gnt0, gnt1}), 32'd0);

    // Port 1 locked 6-beat burst with port 0 pending: 4 x gnt1, gnt0, 2 x gnt1
    for (int i = 0; i < 6; i++)
      q1.push_back(mk(1'b1, (i != 5), 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 2'd3));
    @(negedge clk); chk("t3_nognt", 32'({gnt0, gnt1}), 32'd0);
    q0.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 2'd3));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("t3_seq%0d", i), 32'({gnt0, gnt1}), (i == 4) ? 32'd2 : 32'd1);
      if (i == 5) begin
        chk("t3_rvalid0", 32'(rvalid0), 32'd1);
        chk("t3_rdata0", rdata0, 32'hDEADBEEF);
      end
    end
    @(negedge clk); chk("t3_idle", 32'({gnt0, gnt1}), 32'd0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_mem%0d", i), mem[128 + i], 32'hB000_0000 + 32'(i));

    // Byte write into the low byte of the earlier word
    q0.push_back(mk(1'b1, 1'b0, 32'h103, 32'h0000_00AB, 2'd0));
    wait_gnt(0, "t4_wr_gnt");
    q0.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 2'd3));
    wait_gnt(0, "t4_rd_gnt");
    @(negedge clk);
    chk("t4_rvalid", 32'(rvalid0), 32'd1);
    chk("t4_rdata", rdata0, 32'hDEADBEAB);

    // Reset during the second beat of a locked write burst
    for (int i = 0; i < 4; i++)
      q0.push_back(mk(1'b1, (i != 3), 32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'd3));
    wait_gnt(0, "t5_gnt_b0");
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("t5_gnt_b1", 32'(gnt0), 32'd1);
    chk("t5_we_gated", 32'(mem_we), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_flags", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we}), 32'd0);
    chk("t5_maddr", mem_addr, 32'd0);
    chk("t5_rdata0", rdata0, 32'd0);
    chk("t5_mem_b0", mem[192], 32'hC000_0000);
    chk("t5_mem_b1", mem[193], 32'd0);

    // Misaligned word write to 0x102
    q0.push_back(mk(1'b1, 1'b0, 32'h102, 32'h1234_5678, 2'd3));
    wait_gnt(0, "t6_gnt");
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("t6_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("t6_err", 32'(err0), 32'd1);
    chk("t6_rvalid", 32'(rvalid0), 32'd0);
    chk("t6_mem", mem[64], 32'hDEADBEAB);
`else
    chk("t6_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("t6_err", 32'(err0), 32'd0);
    chk("t6_rvalid", 32'(rvalid0), 32'd0);
    chk("t6_mem", mem[64], 32'h1234_5678);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
